stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
// PURPOSE
// Shares one 32-bit stb/ack output stream (e.g. output_rs232_tx) among N_REQ
// producer processes inside user_design. Round-robin grant with burst limit;
// one registered output stage. Sticky exception on requester protocol violation,
// ORed into the top-level exception like every other process.
// PARAMETERS
// N_REQ      4    number of requesters (>=1)
// WIDTH      32   data width per stream
// MAX_BURST  16   words per grant before forced release; 0 = unlimited
// PORTS
// clk            in   1            system clock
// rst            in   1            asynchronous, active-low reset
// in_data        in   N_REQ*WIDTH  requester words, req i at [i*WIDTH +: WIDTH]
// in_stb         in   N_REQ        requester strobes
// in_ack         out  N_REQ        requester acks (combinational)
// out_data       out  WIDTH        shared stream data (registered)
// out_stb        out  1            shared stream strobe (registered)
// out_ack        in   1            shared stream ack
// grant_valid    out  1            high in XFER
// grant_id       out  max(1,$clog2(N_REQ))  current grantee
// exception      out  1            sticky protocol-violation flag
// BEHAVIOUR
// - rst low (async): state=IDLE, out_stb=0, out_data=0, ptr=0, count=0,
//   exception=0, grant_valid=0, grant_id=0; in_ack=0 combinationally.
//   Word in output register is discarded; no partial burst resumes.
// - States: IDLE, XFER. IDLE: if any in_stb, pick first set bit scanning
//   ptr, ptr+1.. mod N_REQ; next cycle XFER with grant=pick, count=0.
//   IDLE with no in_stb: stay. One bubble cycle per arbitration.
// - XFER: in_ack[grant] = in_stb[grant] && (!out_stb || out_ack); others 0.
//   Accept loads out_data<=in_data[grant], out_stb<=1, count<=count+1.
//   out_stb&&out_ack without accept: out_stb<=0. Latency accept->out_stb = 1.
//   Full throughput: accept and output drain may happen in same cycle.
// - Release (->IDLE, ptr<=grant+1 mod N_REQ) when: in_stb[grant]=0, or
//   accept of word number MAX_BURST (MAX_BURST!=0). Output register keeps
//   draining in IDLE; next grant may accept only when (!out_stb || out_ack).
// - count width $clog2(MAX_BURST+1); never wraps (release precedes overflow).
// - Violation: in XFER, in_stb[grant] high last cycle, not acked, low now ->
//   exception<=1, still release. Cleared only by reset.
// - out_data/out_stb stable while out_stb && !out_ack.
// - N_REQ=1: ptr constant 0; arbitration degenerates, bubble still present.
// STRUCTURE
// - Package stream_arb_pkg: state enum {IDLE,XFER}, GRANT_W function
//   (max(1,$clog2(n))), rr_next(ptr,n) helper.
// - Sub-module rr_priority_pick: combinational rotate-priority picker
//   (req vector, ptr -> onehot + index + any). Rest in top.
// TESTING
// 1 Reset: assert rst=0 mid-burst with out_stb=1 -> out_stb, grant_valid,
//   exception, in_ack all 0 immediately, before next clk edge.
// 2 Single stream: req0 offers 0x11,0x12,0x13 from cycle 0, out_ack=1 ->
//   grant cycle 1, out_data 0x11/0x12/0x13 with out_stb on cycles 2,3,4.
// 3 Fairness: N_REQ=4, MAX_BURST=2, all stb high continuously -> grant order
//   0,1,2,3,0; exactly 2 words each; one IDLE cycle between grants.
// 4 Backpressure: out_ack=0 for 5 cycles during burst -> out_data constant,
//   in_ack=0, sequence at output has no loss or duplication.
// 5 Violation: req1 granted, out_ack=0, req1 drops stb unacked -> exception=1
//   next cycle, stays 1 until rst, grant released.
// 6 Tie: req1 releases (ptr=2) while req0 and req2 request -> req2 granted.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned GRANT_W(input int unsigned n);
    return (n <= 1) ? 1 : unsigned'($clog2(n));
  endfunction

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and shared-stream signals of the round-robin arbiter.
interface stream_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 32
);
  import stream_arb_pkg::*;

  localparam int unsigned GW = GRANT_W(N_REQ);

  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       in_stb;
  logic [N_REQ-1:0]       in_ack;
  logic [WIDTH-1:0]       out_data;
  logic                   out_stb;
  logic                   out_ack;
  logic                   grant_valid;
  logic [GW-1:0]          grant_id;
  logic                   exception;

  modport master (
    input  in_data, in_stb, out_ack,
    output in_ack, out_data, out_stb, grant_valid, grant_id, exception
  );

  modport slave (
    output in_data, in_stb, out_ack,
    input  in_ack, out_data, out_stb, grant_valid, grant_id, exception
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set request scanning from ptr upward, modulo N_REQ.
module rr_priority_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot_c,
  output logic [GW-1:0]    idx_c,
  output logic             any_c
);

  logic [GW:0] pos;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    pos      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      pos = {1'b0, ptr} + (GW+1)'(k);
      if (pos >= (GW+1)'(N_REQ)) pos = pos - (GW+1)'(N_REQ);
      if (!any_c && req[pos[GW-1:0]]) begin
        any_c                = 1'b1;
        onehot_c[pos[GW-1:0]] = 1'b1;
        idx_c                = pos[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered stb/ack stream among N_REQ producers,
// with a per-grant burst limit and a sticky protocol-violation flag.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input logic                 clk,
  input logic                 rst,
  stream_rr_arbiter_if.master bus
);

  localparam int unsigned GW    = GRANT_W(N_REQ);
  localparam int unsigned CNT_W = (MAX_BURST == 0) ? 1 : unsigned'($clog2(MAX_BURST + 1));
  localparam logic [0:0]  IDLE  = ST_IDLE;
  localparam logic [0:0]  XFER  = ST_XFER;

  logic [0:0]       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exc_q, exc_d;
  logic             gv_q, gv_d;
  logic             pend_q, pend_d;
  logic             ostb_q, ostb_d;
  logic [WIDTH-1:0] odata_q, odata_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [GW-1:0]    pick_idx;
  logic             pick_any;
  logic             sel_stb;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             last_word;
  logic             violation;
  logic [N_REQ-1:0] ack_vec;

  rr_priority_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req      (bus.in_stb),
    .ptr      (ptr_q),
    .onehot_c (pick_onehot),
    .idx_c    (pick_idx),
    .any_c    (pick_any)
  );

  // Grantee's strobe and data, plus the combinational ack back to it.
  always_comb begin
    sel_stb  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_q == GW'(i)) begin
        sel_stb  = bus.in_stb[i];
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept    = (state_q == XFER) && sel_stb && (!ostb_q || bus.out_ack);
  assign last_word = (MAX_BURST != 0) && (count_q == CNT_W'(MAX_BURST - 1));
  assign violation = (state_q == XFER) && pend_q && !sel_stb;

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < int'(N_REQ); i++) ack_vec[i] = accept && (grant_q == GW'(i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      exc_q   <= 1'b0;
      gv_q    <= 1'b0;
      pend_q  <= 1'b0;
      ostb_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      exc_q   <= exc_d;
      gv_q    <= gv_d;
      pend_q  <= pend_d;
      ostb_q  <= ostb_d;
      odata_q <= odata_d;
    end
  end

  // pend tracks "grantee strobing but not yet acked", so a drop without ack is a violation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    exc_d   = exc_q;
    gv_d    = gv_q;
    pend_d  = pend_q;
    ostb_d  = ostb_q;
    odata_d = odata_q;

    case (state_q)
      IDLE: begin
        pend_d = |(pick_onehot & bus.in_stb);
        if (pick_any) begin
          state_d = XFER;
          grant_d = pick_idx;
          count_d = '0;
          gv_d    = 1'b1;
        end
      end
      XFER: begin
        pend_d = sel_stb && !accept;
        if (accept && (MAX_BURST != 0)) count_d = count_q + CNT_W'(1);
        if (violation) exc_d = 1'b1;
        if (!sel_stb || (accept && last_word)) begin
          state_d = IDLE;
          gv_d    = 1'b0;
          ptr_d   = GW'(rr_next(32'(grant_q), N_REQ));
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register: load on accept, otherwise drain when the consumer acks.
    if (accept) begin
      odata_d = sel_data;
      ostb_d  = 1'b1;
    end else if (ostb_q && bus.out_ack) begin
      ostb_d = 1'b0;
    end
  end

  assign bus.in_ack      = ack_vec;
  assign bus.out_data    = odata_q;
  assign bus.out_stb     = ostb_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_id    = grant_q;
  assign bus.exception   = exc_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: one instance with MAX_BURST=16, one with MAX_BURST=2.
module tb_stream_rr_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.N_REQ(NR), .WIDTH(W)) a_if ();
  stream_rr_arbiter_if #(.N_REQ(NR), .WIDTH(W)) b_if ();

  stream_rr_arbiter #(.N_REQ(NR), .WIDTH(W), .MAX_BURST(16)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if.master)
  );

  stream_rr_arbiter #(.N_REQ(NR), .WIDTH(W), .MAX_BURST(2)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if.master)
  );

  // Producer model for instance A: each requester offers words[r][pos..len-1].
  logic [W-1:0]  words [NR][8];
  int            len   [NR];
  int            pos   [NR];
  logic [NR-1:0] acked;
  logic [W-1:0]  got   [$];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      a_if.in_stb[i]          = (pos[i] < len[i]);
      a_if.in_data[i*W +: W]  = (pos[i] < len[i]) ? words[i][pos[i] % 8] : '0;
    end
    #1;
  endtask

  task automatic load(input int r, input logic [W-1:0] base, input int n);
    for (int k = 0; k < n; k++) words[r][k] = base + W'(k);
    len[r] = n;
    pos[r] = 0;
    drive();
  endtask

  task automatic clear();
    for (int i = 0; i < NR; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    got.delete();
    drive();
  endtask

  // One clock: record acks and output handshakes at negedge, advance producers after posedge.
  task automatic step();
    @(negedge clk);
    acked = a_if.in_ack;
    if (a_if.out_stb && a_if.out_ack) got.push_back(a_if.out_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acked[i]) pos[i]++;
    drive();
  endtask

  task automatic test_power_on();
    a_if.out_ack = 1'b0;
    b_if.in_stb  = '0;
    b_if.in_data = '0;
    b_if.out_ack = 1'b0;
    clear();
    rst = 1'b0;
    #1;
    n_tests++; if (a_if.out_stb !== 1'b0) begin n_fail++; $display("FAIL por_out_stb: got %b want 0", a_if.out_stb); end
    n_tests++; if (a_if.grant_valid !== 1'b0) begin n_fail++; $display("FAIL por_grant_valid: got %b want 0", a_if.grant_valid); end
    n_tests++; if (a_if.exception !== 1'b0) begin n_fail++; $display("FAIL por_exception: got %b want 0", a_if.exception); end
    n_tests++; if (a_if.grant_id !== 2'd0) begin n_fail++; $display("FAIL por_grant_id: got %0d want 0", a_if.grant_id); end
    n_tests++; if (a_if.out_data !== 32'h0) begin n_fail++; $display("FAIL por_out_data: got %h want 0", a_if.out_data); end
    n_tests++; if (b_if.grant_valid !== 1'b0) begin n_fail++; $display("FAIL por_b_grant_valid: got %b want 0", b_if.grant_valid); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_fairness();
    int            ack_cnt [NR];
    logic          exp_gv;
    logic [1:0]    exp_id;
    logic [NR-1:0] exp_ack;
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    b_if.in_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    b_if.out_ack = 1'b1;
    b_if.in_stb  = 4'hF;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      exp_gv  = (c % 3) != 0;
      exp_id  = 2'(((c - 1) / 3) % 4);
      exp_ack = exp_gv ? (4'b0001 << exp_id) : 4'b0000;
      n_tests++; if (b_if.grant_valid !== exp_gv) begin n_fail++; $display("FAIL fair_gv c%0d: got %b want %b", c, b_if.grant_valid, exp_gv); end
      if (exp_gv) begin
        n_tests++; if (b_if.grant_id !== exp_id) begin n_fail++; $display("FAIL fair_id c%0d: got %0d want %0d", c, b_if.grant_id, exp_id); end
      end
      n_tests++; if (b_if.in_ack !== exp_ack) begin n_fail++; $display("FAIL fair_ack c%0d: got %b want %b", c, b_if.in_ack, exp_ack); end
      for (int i = 0; i < NR; i++) if (b_if.in_ack[i]) ack_cnt[i]++;
    end
    b_if.in_stb = '0;
    n_tests++; if (ack_cnt[0] != 4) begin n_fail++; $display("FAIL fair_words_r0: got %0d want 4", ack_cnt[0]); end
    for (int i = 1; i < NR; i++) begin
      n_tests++; if (ack_cnt[i] != 2) begin n_fail++; $display("FAIL fair_words_r%0d: got %0d want 2", i, ack_cnt[i]); end
    end
  endtask

  task automatic test_single();
    a_if.out_ack = 1'b1;
    load(0, 32'h11, 3);
    n_tests++; if (a_if.grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_gv: got %b want 0", a_if.grant_valid); end
    step();
    n_tests++; if (a_if.grant_valid !== 1'b1 || a_if.grant_id !== 2'd0) begin n_fail++; $display("FAIL single_c1_grant: got gv=%b id=%0d want gv=1 id=0", a_if.grant_valid, a_if.grant_id); end
    n_tests++; if (a_if.in_ack !== 4'b0001) begin n_fail++; $display("FAIL single_c1_ack: got %b want 0001", a_if.in_ack); end
    n_tests++; if (a_if.out_stb !== 1'b0) begin n_fail++; $display("FAIL single_c1_stb: got %b want 0", a_if.out_stb); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++; if (a_if.out_stb !== 1'b1 || a_if.out_data !== 32'h11 + W'(k)) begin n_fail++; $display("FAIL single_c%0d_out: got stb=%b data=%h want stb=1 data=%h", k + 2, a_if.out_stb, a_if.out_data, 32'h11 + W'(k)); end
    end
    step();
    n_tests++; if (a_if.grant_valid !== 1'b0 || a_if.out_stb !== 1'b0) begin n_fail++; $display("FAIL single_c5_idle: got gv=%b stb=%b want 0 0", a_if.grant_valid, a_if.out_stb); end
    n_tests++; if (a_if.exception !== 1'b0) begin n_fail++; $display("FAIL single_exception: got %b want 0", a_if.exception); end
  endtask

  task automatic test_backpressure();
    got.delete();
    a_if.out_ack = 1'b1;
    load(0, 32'h41, 6);
    repeat (3) step();
    a_if.out_ack = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      n_tests++; if (a_if.out_stb !== 1'b1 || a_if.out_data !== 32'h42) begin n_fail++; $display("FAIL bp_hold s%0d: got stb=%b data=%h want stb=1 data=42", s, a_if.out_stb, a_if.out_data); end
      n_tests++; if (a_if.in_ack !== 4'b0000) begin n_fail++; $display("FAIL bp_ack s%0d: got %b want 0000", s, a_if.in_ack); end
      if (s < 4) step();
    end
    step();
    a_if.out_ack = 1'b1;
    #1;
    for (int t = 0; t < 30 && got.size() < 6; t++) step();
    n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d words want 6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      n_tests++; if (got[k] !== 32'h41 + W'(k)) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", k, got[k], 32'h41 + W'(k)); end
    end
    repeat (2) step();
  endtask

  task automatic test_violation();
    got.delete();
    a_if.out_ack = 1'b0;
    load(1, 32'h51, 3);
    step();
    n_tests++; if (a_if.grant_valid !== 1'b1 || a_if.grant_id !== 2'd1) begin n_fail++; $display("FAIL viol_grant: got gv=%b id=%0d want gv=1 id=1", a_if.grant_valid, a_if.grant_id); end
    n_tests++; if (a_if.in_ack !== 4'b0010) begin n_fail++; $display("FAIL viol_first_ack: got %b want 0010", a_if.in_ack); end
    step();
    n_tests++; if (a_if.in_ack !== 4'b0000 || a_if.out_stb !== 1'b1 || a_if.out_data !== 32'h51) begin n_fail++; $display("FAIL viol_stall: got ack=%b stb=%b data=%h want 0000 1 51", a_if.in_ack, a_if.out_stb, a_if.out_data); end
    step();
    len[1] = pos[1];
    drive();
    n_tests++; if (a_if.exception !== 1'b0 || a_if.grant_valid !== 1'b1) begin n_fail++; $display("FAIL viol_pre: got exc=%b gv=%b want 0 1", a_if.exception, a_if.grant_valid); end
    step();
    n_tests++; if (a_if.exception !== 1'b1) begin n_fail++; $display("FAIL viol_exception: got %b want 1", a_if.exception); end
    n_tests++; if (a_if.grant_valid !== 1'b0) begin n_fail++; $display("FAIL viol_release: got gv=%b want 0", a_if.grant_valid); end
  endtask

  // Continues from the release of req1, so the pointer sits at 2.
  task automatic test_tie();
    load(0, 32'h61, 1);
    load(2, 32'h62, 1);
    step();
    n_tests++; if (a_if.grant_valid !== 1'b1 || a_if.grant_id !== 2'd2) begin n_fail++; $display("FAIL tie_grant: got gv=%b id=%0d want gv=1 id=2", a_if.grant_valid, a_if.grant_id); end
    a_if.out_ack = 1'b1;
    #1;
    n_tests++; if (a_if.in_ack !== 4'b0100) begin n_fail++; $display("FAIL tie_ack: got %b want 0100", a_if.in_ack); end
    step();
    n_tests++; if (a_if.out_stb !== 1'b1 || a_if.out_data !== 32'h62) begin n_fail++; $display("FAIL tie_out: got stb=%b data=%h want 1 62", a_if.out_stb, a_if.out_data); end
    step();
    n_tests++; if (a_if.grant_valid !== 1'b0) begin n_fail++; $display("FAIL tie_bubble: got gv=%b want 0", a_if.grant_valid); end
    step();
    n_tests++; if (a_if.grant_valid !== 1'b1 || a_if.grant_id !== 2'd0) begin n_fail++; $display("FAIL tie_next: got gv=%b id=%0d want gv=1 id=0", a_if.grant_valid, a_if.grant_id); end
    n_tests++; if (a_if.exception !== 1'b1) begin n_fail++; $display("FAIL tie_sticky_exc: got %b want 1", a_if.exception); end
    repeat (3) step();
  endtask

  task automatic test_reset();
    clear();
    repeat (2) step();
    a_if.out_ack = 1'b1;
    load(3, 32'h71, 4);
    repeat (2) step();
    n_tests++; if (a_if.out_stb !== 1'b1 || a_if.grant_id !== 2'd3) begin n_fail++; $display("FAIL rst_pre: got stb=%b id=%0d want 1 3", a_if.out_stb, a_if.grant_id); end
    #1;
    rst = 1'b0;
    #1;
    n_tests++; if (a_if.out_stb !== 1'b0) begin n_fail++; $display("FAIL rst_out_stb: got %b want 0", a_if.out_stb); end
    n_tests++; if (a_if.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_grant_valid: got %b want 0", a_if.grant_valid); end
    n_tests++; if (a_if.exception !== 1'b0) begin n_fail++; $display("FAIL rst_exception: got %b want 0", a_if.exception); end
    n_tests++; if (a_if.in_ack !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ack: got %b want 0000", a_if.in_ack); end
    n_tests++; if (a_if.grant_id !== 2'd0 || a_if.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_regs: got id=%0d data=%h want 0 0", a_if.grant_id, a_if.out_data); end
    clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    n_tests++; if (a_if.out_stb !== 1'b0 || a_if.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after: got stb=%b gv=%b want 0 0", a_if.out_stb, a_if.grant_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    test_power_on();
    test_fairness();
    test_single();
    test_backpressure();
    test_violation();
    test_tie();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
